// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains the async-FIFO read port and
// serialises each byte as a UART 8N1 frame on tx (rclk domain).
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        START,
        DATA,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  r_en_q, r_en_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  baud_end;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            r_en_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            r_en_q  <= r_en_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = LATCH;
            end
            LATCH: begin
                shift_d = data_out;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so the line never glitches.
    always_comb begin
        r_en_d = (state_d == RD);
        done_d = (state_q == STOP) && (state_d == IDLE);
        tx_d   = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    assign r_en    = r_en_q;
    assign tx      = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: randomized bench with a FIFO model and a
// trace decoder that rebuilds UART frames from the sampled tx line.
module tb_uart_tx_fifo_drain;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       empty;
    logic [7:0] data_out = 8'h00;
    logic       r_en, tx, busy, tx_done;
    logic       hold_empty = 1'b0;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int underflows = 0;
    int tests = 0;
    int fails = 0;

    bit t_tx[$], t_ren[$], t_busy[$], t_done[$];
    logic [7:0] d_bytes[$];
    int d_start[$];
    int d_bad, d_ren, d_ren_bad, d_done, d_done_bad;
    int d_busy_bad, d_overlap, d_txlow;

    uart_tx_fifo_drain #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .empty   (empty),
        .data_out(data_out),
        .r_en    (r_en),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 rclk = ~rclk;

    assign empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (r_en) begin
            if (empty) underflows <= underflows + 1;
            data_out <= mem[rd_ptr[5:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic capture(input int n);
        t_tx.delete();
        t_ren.delete();
        t_busy.delete();
        t_done.delete();
        repeat (n) begin
            @(negedge rclk);
            t_tx.push_back(tx);
            t_ren.push_back(r_en);
            t_busy.push_back(busy);
            t_done.push_back(tx_done);
        end
    endtask

    // Rebuilds frames from the tx trace and tallies protocol anomalies.
    task automatic decode();
        int n;
        int i;
        logic [7:0] b;
        bit ok, lvl, exp_busy, hit;
        n = t_tx.size();
        i = 0;
        d_bytes.delete();
        d_start.delete();
        d_bad = 0; d_ren = 0; d_ren_bad = 0; d_done = 0;
        d_done_bad = 0; d_busy_bad = 0; d_overlap = 0; d_txlow = 0;
        while (i < n) begin
            if (t_tx[i] == 1'b0) begin
                if (i + FRAME > n) begin
                    d_bad++;
                    break;
                end
                b = 8'h00;
                ok = 1'b1;
                for (int s = 0; s < 10; s++) begin
                    lvl = t_tx[i + s * CPB];
                    for (int c = 1; c < CPB; c++)
                        if (t_tx[i + s * CPB + c] != lvl) ok = 1'b0;
                    if (s == 9 && lvl != 1'b1) ok = 1'b0;
                    if (s >= 1 && s <= 8) b[s-1] = lvl;
                end
                if (!ok) d_bad++;
                d_bytes.push_back(b);
                d_start.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
        for (int k = 0; k < n; k++) begin
            exp_busy = 1'b0;
            foreach (d_start[j])
                if (k >= d_start[j] - 2 && k < d_start[j] + FRAME) exp_busy = 1'b1;
            if (t_busy[k] != exp_busy) d_busy_bad++;
            if (t_ren[k]) begin
                d_ren++;
                hit = 1'b0;
                foreach (d_start[j]) if (d_start[j] == k + 2) hit = 1'b1;
                if (!hit) d_ren_bad++;
            end
            if (t_done[k]) begin
                d_done++;
                hit = 1'b0;
                foreach (d_start[j]) if (d_start[j] + FRAME == k) hit = 1'b1;
                if (!hit) d_done_bad++;
            end
            if (t_busy[k] && t_done[k]) d_overlap++;
            if (!t_tx[k]) d_txlow++;
        end
    endtask

    task automatic test_reset();
        int rd0;
        rrst = 1'b1;
        hold_empty = 1'b0;
        @(negedge rclk);
        push(8'hA5);
        rd0 = rd_ptr;
        for (int k = 0; k < 10; k++) begin
            @(negedge rclk);
            tests++;
            if ({tx, r_en, busy, tx_done} !== 4'b1000) begin
                fails++;
                $display("FAIL reset_outputs cyc%0d: tx,r_en,busy,done=%b expected 1000",
                         k, {tx, r_en, busy, tx_done});
            end
        end
        tests++;
        if (rd_ptr !== rd0) begin
            fails++;
            $display("FAIL reset_no_read: reads=%0d expected 0", rd_ptr - rd0);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] pat;
        int mis;
        pat = 10'b1101001010;
        rrst = 1'b0;
        capture(60);
        decode();
        tests++;
        if (d_start.size() != 1 || d_bytes[0] !== 8'hA5) begin
            fails++;
            $display("FAIL single_byte: frames=%0d first=%h expected 1 frame a5",
                     d_start.size(), d_bytes.size() ? d_bytes[0] : 8'h00);
        end
        tests++;
        if (d_start.size() > 0 && d_start[0] != 2) begin
            fails++;
            $display("FAIL single_latency: start idx=%0d expected 2", d_start[0]);
        end
        mis = 0;
        if (d_start.size() > 0)
            for (int k = 0; k < FRAME; k++)
                if (t_tx[d_start[0] + k] != pat[k / CPB]) mis++;
        tests++;
        if (d_start.size() == 0 || mis != 0) begin
            fails++;
            $display("FAIL single_wave: bad samples=%0d frames=%0d expected 0 and 1",
                     mis, d_start.size());
        end
        tests++;
        if (d_ren != 1 || d_ren_bad != 0) begin
            fails++;
            $display("FAIL single_ren: pulses=%0d misplaced=%0d expected 1/0", d_ren, d_ren_bad);
        end
        tests++;
        if (d_done != 1 || d_done_bad != 0) begin
            fails++;
            $display("FAIL single_done: pulses=%0d misplaced=%0d expected 1/0", d_done, d_done_bad);
        end
        tests++;
        if (d_busy_bad != 0 || d_overlap != 0 || d_bad != 0) begin
            fails++;
            $display("FAIL single_busy: busy_err=%0d overlap=%0d bad=%0d expected 0",
                     d_busy_bad, d_overlap, d_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        int mis;
        int gap;
        exp = '{8'h00, 8'hFF, 8'h55};
        foreach (exp[j]) push(exp[j]);
        capture(150);
        decode();
        mis = 0;
        foreach (exp[j]) if (j >= d_bytes.size() || d_bytes[j] !== exp[j]) mis++;
        tests++;
        if (d_bytes.size() != 3 || mis != 0 || d_bad != 0) begin
            fails++;
            $display("FAIL b2b_data: frames=%0d wrong=%0d bad=%0d expected 3/0/0",
                     d_bytes.size(), mis, d_bad);
        end
        tests++;
        if (d_ren != 3 || d_ren_bad != 0 || d_done != 3 || d_done_bad != 0) begin
            fails++;
            $display("FAIL b2b_pulses: ren=%0d/%0d done=%0d/%0d expected 3/0 3/0",
                     d_ren, d_ren_bad, d_done, d_done_bad);
        end
        for (int j = 1; j < d_start.size(); j++) begin
            gap = d_start[j] - d_start[j-1] - FRAME;
            tests++;
            if (gap != 3) begin
                fails++;
                $display("FAIL b2b_gap%0d: gap=%0d expected 3", j, gap);
            end
        end
        tests++;
        if (d_busy_bad != 0 || d_overlap != 0) begin
            fails++;
            $display("FAIL b2b_busy: busy_err=%0d overlap=%0d expected 0", d_busy_bad, d_overlap);
        end
    endtask

    task automatic test_idle_empty();
        int rd0;
        rd0 = rd_ptr;
        hold_empty = 1'b1;
        push(8'h3C);
        capture(200);
        decode();
        tests++;
        if (d_ren != 0 || rd_ptr != rd0) begin
            fails++;
            $display("FAIL idle_ren: pulses=%0d reads=%0d expected 0", d_ren, rd_ptr - rd0);
        end
        tests++;
        if (d_txlow != 0 || d_busy_bad != 0 || d_done != 0) begin
            fails++;
            $display("FAIL idle_line: txlow=%0d busy=%0d done=%0d expected 0",
                     d_txlow, d_busy_bad, d_done);
        end
        hold_empty = 1'b0;
        capture(60);
        decode();
        tests++;
        if (d_bytes.size() != 1 || d_bytes[0] !== 8'h3C) begin
            fails++;
            $display("FAIL idle_release: frames=%0d first=%h expected 1 frame 3c",
                     d_bytes.size(), d_bytes.size() ? d_bytes[0] : 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        push(8'hC3);
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge rclk);
            if (r_en) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL mid_wait_ren: r_en=0 after 20 cycles expected 1");
        end
        if (found) begin
            repeat (19) @(negedge rclk);
            tests++;
            if (tx !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL mid_bit3: tx=%b busy=%b expected 0 1", tx, busy);
            end
            rrst = 1'b1;
            #1;
            tests++;
            if ({tx, busy, tx_done, r_en} !== 4'b1000) begin
                fails++;
                $display("FAIL mid_async: tx,busy,done,r_en=%b expected 1000",
                         {tx, busy, tx_done, r_en});
            end
            repeat (2) @(negedge rclk);
            rrst = 1'b0;
            capture(60);
            decode();
            tests++;
            if (d_done != 0 || d_ren != 0 || d_txlow != 0 || d_busy_bad != 0) begin
                fails++;
                $display("FAIL mid_after: done=%0d ren=%0d txlow=%0d busy=%0d expected 0",
                         d_done, d_ren, d_txlow, d_busy_bad);
            end
            tests++;
            if (rd_ptr != wr_ptr) begin
                fails++;
                $display("FAIL mid_fifo: pending=%0d expected 0", wr_ptr - rd_ptr);
            end
        end
    endtask

    task automatic test_empty_rise();
        logic [7:0] a, b;
        int rd0;
        a = 8'($urandom);
        b = 8'($urandom);
        rd0 = rd_ptr;
        push(a);
        fork
            capture(60);
            begin
                repeat (4) @(negedge rclk);
                hold_empty = 1'b1;
                push(b);
            end
        join
        decode();
        tests++;
        if (d_bytes.size() != 1 || d_bytes[0] !== a || d_bad != 0) begin
            fails++;
            $display("FAIL rise_frame: frames=%0d first=%h bad=%0d expected 1 %h 0",
                     d_bytes.size(), d_bytes.size() ? d_bytes[0] : 8'h00, d_bad, a);
        end
        tests++;
        if (d_ren != 1 || rd_ptr - rd0 != 1 || d_done != 1) begin
            fails++;
            $display("FAIL rise_reads: ren=%0d reads=%0d done=%0d expected 1 1 1",
                     d_ren, rd_ptr - rd0, d_done);
        end
        hold_empty = 1'b0;
        capture(60);
        decode();
        tests++;
        if (d_bytes.size() != 1 || d_bytes[0] !== b) begin
            fails++;
            $display("FAIL rise_release: frames=%0d first=%h expected 1 %h",
                     d_bytes.size(), d_bytes.size() ? d_bytes[0] : 8'h00, b);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        int d;
        int gap;
        int exp_gap;
        for (int it = 0; it < 6; it++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            d = $urandom_range(1, 60);
            push(a);
            fork
                capture(140);
                begin
                    repeat (d) @(negedge rclk);
                    push(b);
                end
            join
            decode();
            tests++;
            if (d_bytes.size() != 2 || d_bytes[0] !== a || d_bytes[1] !== b || d_bad != 0) begin
                fails++;
                $display("FAIL rand%0d_data: frames=%0d bad=%0d expected 2 frames %h %h",
                         it, d_bytes.size(), d_bad, a, b);
            end
            tests++;
            if (d_ren != 2 || d_done != 2 || d_ren_bad + d_done_bad + d_busy_bad + d_overlap != 0) begin
                fails++;
                $display("FAIL rand%0d_ctrl: ren=%0d done=%0d errs=%0d expected 2 2 0",
                         it, d_ren, d_done, d_ren_bad + d_done_bad + d_busy_bad + d_overlap);
            end
            exp_gap = (d <= 43) ? 3 : d - 40;
            gap = (d_start.size() == 2) ? d_start[1] - d_start[0] - FRAME : -1;
            tests++;
            if (gap != exp_gap) begin
                fails++;
                $display("FAIL rand%0d_gap: gap=%0d expected %0d (push delay %0d)",
                         it, gap, exp_gap, d);
            end
        end
        tests++;
        if (underflows != 0) begin
            fails++;
            $display("FAIL underflow: reads while empty=%0d expected 0", underflows);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_idle_empty();
        test_reset_mid();
        test_empty_rise();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
